// File: rtl/regfile_sb.sv
// Integer register file with per-register busy scoreboard,
// writeback bypass and a single-stage debug read port.
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW = $clog2(NREG),
  localparam int CW = $clog2(NREG + 1)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_val,
  output logic [XLEN-1:0] rs2_val,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_val,
  input  logic            dbg_req,
  input  logic [AW-1:0]   dbg_addr,
  output logic            dbg_ack,
  output logic [XLEN-1:0] dbg_val,
  output logic [CW-1:0]   busy_cnt
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic            wb_hit;
  logic            iss_hit;
  logic            cnt_inc;
  logic            cnt_dec;
  logic [XLEN-1:0] dbg_rd;

  assign wb_hit  = wb_valid && (wb_rd != '0);
  assign iss_hit = iss_valid && (iss_rd != '0);

  function automatic logic byp(input logic [AW-1:0] a);
    return wb_hit && (wb_rd == a);
  endfunction

  always_comb begin
    rs1_val  = '0;
    rs1_busy = 1'b0;
    if (reset_n && (rs1_addr != '0)) begin
      if (byp(rs1_addr)) begin
        rs1_val = wb_val;
      end else begin
        rs1_val  = regs[rs1_addr];
        rs1_busy = busy[rs1_addr];
      end
    end
  end

  always_comb begin
    rs2_val  = '0;
    rs2_busy = 1'b0;
    if (reset_n && (rs2_addr != '0)) begin
      if (byp(rs2_addr)) begin
        rs2_val = wb_val;
      end else begin
        rs2_val  = regs[rs2_addr];
        rs2_busy = busy[rs2_addr];
      end
    end
  end

  always_comb begin
    dbg_rd = '0;
    if (dbg_addr != '0) begin
      if (byp(dbg_addr)) dbg_rd = wb_val;
      else               dbg_rd = regs[dbg_addr];
    end
  end

  // a same-edge reservation overrides the writeback clear
  always_comb begin
    busy_nxt = busy;
    if (wb_hit)  busy_nxt[wb_rd]  = 1'b0;
    if (iss_hit) busy_nxt[iss_rd] = 1'b1;
  end

  assign cnt_inc = iss_hit && !busy[iss_rd];
  assign cnt_dec = wb_hit && busy[wb_rd] &&
                   !(iss_hit && (iss_rd == wb_rd));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_hit) begin
      regs[wb_rd] <= wb_val;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy <= busy_nxt;
      unique case ({cnt_inc, cnt_dec})
        2'b10:   busy_cnt <= busy_cnt + CW'(1);
        2'b01:   busy_cnt <= busy_cnt - CW'(1);
        default: busy_cnt <= busy_cnt;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dbg_ack <= 1'b0;
      dbg_val <= '0;
    end else begin
      dbg_ack <= dbg_req;
      if (dbg_req) dbg_val <= dbg_rd;
    end
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with a per-register busy scoreboard and a handshaked debug read port. It replaces the fixed 32×32 register file in the core's decode/writeback path. It adds explicit write enables, write-to-read bypass, and in-flight result tracking so that decode can stall on RAW hazards from multi-cycle units. It also exposes a single generic debug port in place of hard-wired debug taps.

## Interface
- XLEN, 32, data width in bits (≥8)
- NREG, 32, number of registers; power of two, ≥2
- AW, $clog2(NREG), address width (derived, not overridden)
- CW, $clog2(NREG+1), busy counter width (derived)

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- rs1_addr  in  AW  read port 1 address
- rs2_addr  in  AW  read port 2 address
- rs1_val  out  XLEN  read port 1 data (combinational)
- rs2_val  out  XLEN  read port 2 data (combinational)
- rs1_busy  out  1  rs1 has an outstanding reservation (combinational)
- rs2_busy  out  1  rs2 has an outstanding reservation (combinational)
- iss_valid  in  1  reserve iss_rd this cycle
- iss_rd  in  AW  destination being reserved
- wb_valid  in  1  write wb_val to wb_rd this cycle
- wb_rd  in  AW  writeback destination
- wb_val  in  XLEN  writeback data
- dbg_req  in  1  debug read request
- dbg_addr  in  AW  debug read address
- dbg_ack  out  1  debug data valid (one-cycle pulse)
- dbg_val  out  XLEN  debug read data
- busy_cnt  out  CW  number of registers currently reserved

## Operation
- Register 0 reads as 0, is never written, and is never busy. Issue or writeback targeting 0 is ignored, including for the counter.
- Write: when wb_valid and wb_rd≠0, regs[wb_rd] ← wb_val and busy[wb_rd] ← 0 at the edge.
- Reserve: when iss_valid and iss_rd≠0, busy[iss_rd] ← 1 at the edge.
- Same-edge issue and writeback to the same rd: data is written and busy ends at 1, because the new reservation wins.
- Read bypass: if rsN_addr≠0, wb_valid, and wb_rd==rsN_addr, then rsN_val = wb_val and rsN_busy = 0. Otherwise rsN_val = regs[rsN_addr] and rsN_busy = busy[rsN_addr].
- Issue does not affect the same-cycle read outputs.
- Writeback to a register that is not busy is legal: data is written and busy stays 0.
- Issue to an already-busy register (WAW) is legal: busy stays 1.
- busy_cnt always equals popcount(busy). Per edge:
  - +1 when a reservation sets a bit that was 0.
  - −1 when a writeback clears a bit that was 1 and no same-edge reservation hits the same rd.
  - Net change of each edge ∈ {−1, 0, +1}.
- Debug port:
  - A request sampled with dbg_req=1 captures the bypassed value of dbg_addr (same bypass rule as read ports) into dbg_val.
  - dbg_ack=1 in the following cycle.
  - Back-to-back requests give back-to-back acks.
  - dbg_val holds its last value while dbg_ack=0.
- No internal state machine beyond the busy bits and the ack flop. The debug port is a fixed single-stage pipeline.

## Timing
- Reset (reset_n=0, asynchronous assert): all regs, busy bits, busy_cnt, dbg_ack and dbg_val go to 0 immediately. Removal is synchronous to clock.
- During reset, rs1_val and rs2_val read 0 and rs1_busy and rs2_busy read 0. wb, iss and dbg inputs are ignored.
- Reset asserted mid-operation discards all reservations and any debug request in flight; no ack is issued for it.
- Read latency: 0 cycles (combinational from addr and wb inputs).
- Write visibility: the value is visible through bypass in the writeback cycle and from storage in the next cycle.
- Reservation: busy is visible the cycle after iss_valid.
- Debug latency: exactly 1 cycle from request to ack.

## Test plan
- Reset: pulse reset_n low mid-cycle → all outputs 0 immediately. After release, reading regs 1..NREG-1 returns 0 and busy_cnt=0.
- Write/bypass: wb_valid, wb_rd=5, wb_val=0xDEADBEEF with rs1_addr=5 → rs1_val=0xDEADBEEF in the same cycle and from storage the next cycle. A write to rd=0 leaves rs2_addr=0 reading 0.
- Scoreboard: issue rd=7 → rs1_busy(7)=1 and busy_cnt=1 next cycle. Then wb rd=7 val=0x12 → rs1_busy=0 with rs1_val=0x12 in the same cycle, and busy_cnt=0 after the edge.
- Collisions:
  - Issue and wb to rd=9 on the same edge with 9 busy → busy stays 1, busy_cnt unchanged, value written.
  - Issue to busy rd=9 → busy_cnt unchanged.
  - Wb to non-busy rd=3 → busy_cnt unchanged.
- Debug: dbg_req on three consecutive cycles for addresses 1, 2, 3, where reg 2 is being written 0xA5 in its request cycle → dbg_ack high for 3 cycles with values regs[1], 0xA5, regs[3]. dbg_val holds afterwards.
- Parameters: run the full suite with XLEN=16 and NREG=8, including filling all 7 registers → busy_cnt=7, then draining them → busy_cnt=0.
